// File: rtl/fwd_pkg.sv
// Shared encodings for the EX forwarding / load-use hazard unit.
package fwd_pkg;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   localparam int unsigned STALL_CNT_W = 16;
   localparam int unsigned LAT_CNT_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

endpackage

// File: rtl/fwd_select.sv
// One EX operand's forwarding select: MEM result wins over WB, r0 never forwarded.
module fwd_select
   import fwd_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] exSrc,
   input  logic              memRegWrite,
   input  logic [REG_AW-1:0] memWriteReg,
   input  logic              wbRegWrite,
   input  logic [REG_AW-1:0] wbWriteReg,
   output logic [1:0]        fwdSel
);

   always_comb begin
      fwdSel = FWD_RF;
      if (memRegWrite && (memWriteReg != '0) && (memWriteReg == exSrc))
         fwdSel = FWD_MEM;
      else if (wbRegWrite && (wbWriteReg != '0) && (wbWriteReg == exSrc))
         fwdSel = FWD_WB;
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX forwarding selects plus load-use stall FSM with flush override and stall counter.
// Optional ID-stage branch forwarding/hazard enabled by `define FWD_BRANCH_ID_EN.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic                        Clk,
   input  logic                        Rst_n,
   input  logic [NUM_SRC*REG_AW-1:0]   ID_Src,
   input  logic [NUM_SRC-1:0]          ID_SrcUsed,
   input  logic [NUM_SRC*REG_AW-1:0]   EX_Src,
   input  logic                        EX_MemRead,
   input  logic                        EX_RegWrite,
   input  logic [REG_AW-1:0]           EX_WriteReg,
   input  logic                        MemRegWrite,
   input  logic [REG_AW-1:0]           MemWriteReg,
   input  logic                        WBRegWrite,
   input  logic [REG_AW-1:0]           WBWriteReg,
   input  logic                        Flush,
`ifdef FWD_BRANCH_ID_EN
   input  logic                        ID_Branch,
   input  logic                        Mem_MemRead,
   output logic [NUM_SRC-1:0]          BrFwdSel,
`endif
   output logic [2*NUM_SRC-1:0]        FwdSel,
   output logic                        PCWrite,
   output logic                        IFIDWrite,
   output logic                        IDEXBubble,
   output logic [STALL_CNT_W-1:0]      StallCount
);

   localparam logic [LAT_CNT_W-1:0] CNT_INIT =
      LAT_CNT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

   state_t                 state, stateNext;
   logic [LAT_CNT_W-1:0]   cnt, cntNext;
   logic                   loadHit;
   logic                   branchHaz;
   logic                   stall;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sel
      fwd_select #(.REG_AW(REG_AW)) u_sel (
         .exSrc       (EX_Src[g*REG_AW +: REG_AW]),
         .memRegWrite (MemRegWrite),
         .memWriteReg (MemWriteReg),
         .wbRegWrite  (WBRegWrite),
         .wbWriteReg  (WBWriteReg),
         .fwdSel      (FwdSel[2*g +: 2])
      );
   end

   // Load in EX whose destination is read by the instruction in ID.
   always_comb begin
      logic srcHit;
      srcHit = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (ID_SrcUsed[i] && (ID_Src[i*REG_AW +: REG_AW] == EX_WriteReg))
            srcHit = 1'b1;
      end
      loadHit = EX_MemRead && EX_RegWrite && (EX_WriteReg != '0) && srcHit;
   end

`ifdef FWD_BRANCH_ID_EN
   // Branch compares in ID: forward from MEM, stall on EX result or MEM load.
   always_comb begin
      BrFwdSel  = '0;
      branchHaz = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (MemRegWrite && (MemWriteReg != '0) &&
             (MemWriteReg == ID_Src[i*REG_AW +: REG_AW])) begin
            BrFwdSel[i] = 1'b1;
            if (Mem_MemRead && ID_Branch)
               branchHaz = 1'b1;
         end
         if (ID_Branch && EX_RegWrite && (EX_WriteReg != '0) &&
             (EX_WriteReg == ID_Src[i*REG_AW +: REG_AW]))
            branchHaz = 1'b1;
      end
   end
`else
   assign branchHaz = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // The first bubble is raised from IDLE; STALL supplies the remaining LOAD_LAT-1.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            if (!Flush && (loadHit || branchHaz)) begin
               stall = 1'b1;
               if (loadHit && (LOAD_LAT > 1)) begin
                  stateNext = STALL;
                  cntNext   = CNT_INIT;
               end
            end
         end
         STALL: begin
            if (Flush) begin
               stateNext = IDLE;
            end else begin
               stall = 1'b1;
               if (cnt == '0)
                  stateNext = IDLE;
               else
                  cntNext = cnt - LAT_CNT_W'(1);
            end
         end
         default: stateNext = IDLE;
      endcase
      if (!Rst_n)
         stall = 1'b0;
   end

   assign PCWrite    = !stall;
   assign IFIDWrite  = !stall;
   assign IDEXBubble = stall;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         StallCount <= '0;
      else if (stall && (StallCount != '1))
         StallCount <= StallCount + STALL_CNT_W'(1);
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: forwarding-select table plus stall/flush/reset/saturation sequences.
module tb_fwd_hazard_unit;

   logic        Clk;
   logic        rstN;
   logic [9:0]  idSrc;
   logic [1:0]  idSrcUsed;
   logic [9:0]  exSrc;
   logic        exMemRead, exMemRead1;
   logic        exRegWrite;
   logic [4:0]  exWriteReg;
   logic        memRegWrite;
   logic [4:0]  memWriteReg;
   logic        wbRegWrite;
   logic [4:0]  wbWriteReg;
   logic        flush;

   logic [3:0]  fwdSel3, fwdSel1;
   logic        pcWrite3, ifidWrite3, bubble3;
   logic        pcWrite1, ifidWrite1, bubble1;
   logic [15:0] cnt3, cnt1;
`ifdef FWD_BRANCH_ID_EN
   logic [1:0]  brFwd3, brFwd1;
`endif

   int nCmp = 0;
   int nErr = 0;

   fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3)) dut3 (
      .Clk(Clk), .Rst_n(rstN), .ID_Src(idSrc), .ID_SrcUsed(idSrcUsed),
      .EX_Src(exSrc), .EX_MemRead(exMemRead), .EX_RegWrite(exRegWrite),
      .EX_WriteReg(exWriteReg), .MemRegWrite(memRegWrite), .MemWriteReg(memWriteReg),
      .WBRegWrite(wbRegWrite), .WBWriteReg(wbWriteReg), .Flush(flush),
`ifdef FWD_BRANCH_ID_EN
      .ID_Branch(1'b0), .Mem_MemRead(1'b0), .BrFwdSel(brFwd3),
`endif
      .FwdSel(fwdSel3), .PCWrite(pcWrite3), .IFIDWrite(ifidWrite3),
      .IDEXBubble(bubble3), .StallCount(cnt3));

   fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1)) dut1 (
      .Clk(Clk), .Rst_n(rstN), .ID_Src(idSrc), .ID_SrcUsed(idSrcUsed),
      .EX_Src(exSrc), .EX_MemRead(exMemRead1), .EX_RegWrite(exRegWrite),
      .EX_WriteReg(exWriteReg), .MemRegWrite(memRegWrite), .MemWriteReg(memWriteReg),
      .WBRegWrite(wbRegWrite), .WBWriteReg(wbWriteReg), .Flush(flush),
`ifdef FWD_BRANCH_ID_EN
      .ID_Branch(1'b0), .Mem_MemRead(1'b0), .BrFwdSel(brFwd1),
`endif
      .FwdSel(fwdSel1), .PCWrite(pcWrite1), .IFIDWrite(ifidWrite1),
      .IDEXBubble(bubble1), .StallCount(cnt1));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic       memRW;
      logic [4:0] memWR;
      logic       wbRW;
      logic [4:0] wbWR;
      logic [4:0] src0;
      logic [4:0] src1;
      logic [3:0] exp;
   } fwd_vec_t;

   fwd_vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd8,  1'b1, 5'd8,  5'd8,  5'd0,  4'h1};
      vecs[1] = '{1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0,  4'h0};
      vecs[2] = '{1'b1, 5'd0,  1'b1, 5'd9,  5'd0,  5'd9,  4'h8};
      vecs[3] = '{1'b1, 5'd3,  1'b1, 5'd7,  5'd7,  5'd3,  4'h6};
      vecs[4] = '{1'b0, 5'd3,  1'b1, 5'd3,  5'd3,  5'd3,  4'hA};
      vecs[5] = '{1'b1, 5'd31, 1'b0, 5'd31, 5'd31, 5'd30, 4'h1};
      vecs[6] = '{1'b0, 5'd5,  1'b0, 5'd5,  5'd5,  5'd5,  4'h0};
      vecs[7] = '{1'b1, 5'd4,  1'b1, 5'd4,  5'd4,  5'd4,  4'h5};

      // Reset held with a live hazard on both instances
      rstN = 1'b0; flush = 1'b0;
      exSrc = '0; memRegWrite = 1'b0; memWriteReg = '0; wbRegWrite = 1'b0; wbWriteReg = '0;
      exMemRead = 1'b1; exMemRead1 = 1'b1; exRegWrite = 1'b1; exWriteReg = 5'd5;
      idSrc = {5'd5, 5'd2}; idSrcUsed = 2'b10;
      #12;
      chk("rst_pcwrite3", pcWrite3, 1); chk("rst_ifid3", ifidWrite3, 1);
      chk("rst_bubble3", bubble3, 0);   chk("rst_cnt3", cnt3, 0);
      chk("rst_pcwrite1", pcWrite1, 1); chk("rst_cnt1", cnt1, 0);
      exMemRead = 1'b0; exMemRead1 = 1'b0;
      @(negedge Clk); rstN = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         memRegWrite = vecs[i].memRW; memWriteReg = vecs[i].memWR;
         wbRegWrite = vecs[i].wbRW;   wbWriteReg = vecs[i].wbWR;
         exSrc = {vecs[i].src1, vecs[i].src0};
         #1;
         chk($sformatf("fwd3_v%0d", i), fwdSel3, vecs[i].exp);
         chk($sformatf("fwd1_v%0d", i), fwdSel1, vecs[i].exp);
      end

      // LOAD_LAT=1: one bubble, then EX holds the bubble and no re-stall
      @(negedge Clk); exMemRead1 = 1'b1; #1;
      chk("l1_pcwrite", pcWrite1, 0); chk("l1_ifid", ifidWrite1, 0);
      chk("l1_bubble", bubble1, 1);   chk("l1_other_idle", pcWrite3, 1);
      @(negedge Clk); exMemRead1 = 1'b0; #1;
      chk("l1_release", pcWrite1, 1); chk("l1_cnt", cnt1, 1);
      @(negedge Clk); #1;
      chk("l1_cnt_hold", cnt1, 1);

      // LOAD_LAT=3: three bubbles regardless of EX contents during STALL
      @(negedge Clk); exMemRead = 1'b1; #1;
      chk("l3_c1", bubble3, 1);
      @(negedge Clk); exMemRead = 1'b0; #1;
      chk("l3_c2", bubble3, 1); chk("l3_c2_pc", pcWrite3, 0);
      @(negedge Clk); #1;
      chk("l3_c3", bubble3, 1);
      @(negedge Clk); #1;
      chk("l3_done", bubble3, 0); chk("l3_cnt", cnt3, 3);

      // Operand not used, and r0 destination: no hazard
      @(negedge Clk); exMemRead = 1'b1; idSrcUsed = 2'b01; #1;
      chk("unused_src", bubble3, 0);
      @(negedge Clk); #1;
      chk("unused_cnt", cnt3, 3);
      @(negedge Clk); exWriteReg = 5'd0; idSrc = {5'd0, 5'd2}; idSrcUsed = 2'b10; #1;
      chk("r0_dest", bubble3, 0);
      @(negedge Clk); exMemRead = 1'b0; exWriteReg = 5'd5; idSrc = {5'd5, 5'd2}; #1;
      chk("r0_cnt", cnt3, 3);

      // Flush in 2nd stall cycle cancels and returns to IDLE
      @(negedge Clk); exMemRead = 1'b1; #1;
      chk("fl_c1", bubble3, 1);
      @(negedge Clk); exMemRead = 1'b0; flush = 1'b1; #1;
      chk("fl_c2_bubble", bubble3, 0); chk("fl_c2_pc", pcWrite3, 1);
      @(negedge Clk); flush = 1'b0; #1;
      chk("fl_idle", bubble3, 0); chk("fl_cnt", cnt3, 4);

      // Flush alongside a fresh hit in IDLE
      @(negedge Clk); exMemRead = 1'b1; flush = 1'b1; #1;
      chk("fl_hit", bubble3, 0);
      @(negedge Clk); exMemRead = 1'b0; flush = 1'b0; #1;
      chk("fl_hit_next", bubble3, 0); chk("fl_hit_cnt", cnt3, 4);

      // Asynchronous reset in the middle of a stall
      @(negedge Clk); exMemRead = 1'b1; #1;
      chk("rs_c1", bubble3, 1);
      @(negedge Clk); exMemRead = 1'b0; #1;
      chk("rs_c2", bubble3, 1); chk("rs_cnt_pre", cnt3, 5);
      #1 rstN = 1'b0; #1;
      chk("rs_cnt3", cnt3, 0); chk("rs_cnt1", cnt1, 0); chk("rs_pc", pcWrite3, 1);
      #1 rstN = 1'b1;
      @(negedge Clk); #1;
      chk("rs_idle", bubble3, 0); chk("rs_cnt_post", cnt3, 0);

      // Saturation of the stall counter under a permanent hazard
      @(negedge Clk); exMemRead1 = 1'b1;
      repeat (65534) @(negedge Clk);
      #1;
      chk("sat_fffe", cnt1, 16'hFFFE);
      repeat (4466) @(negedge Clk);
      #1;
      chk("sat_ffff", cnt1, 16'hFFFF); chk("sat_stall", pcWrite1, 0);
      exMemRead1 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
